// File: rtl/vec_dist_unit.sv
// rtl/vec_dist_unit.sv - streaming squared-Euclidean / Euclidean / Manhattan distance engine
module vec_dist_unit #(
   parameter int DATA_W     = 16,
   parameter int N_ELEMENTS = 1024,
   parameter int LANES      = 1,
   localparam int ACC_W     = 2*DATA_W + $clog2(N_ELEMENTS),
   localparam int SQRT_W    = (ACC_W + 1) / 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [1:0]              mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] data_a,
   input  logic [LANES*DATA_W-1:0] data_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        result,
   output logic                    busy
);

   localparam int BEATS    = N_ELEMENTS / LANES;
   localparam int CNT_W    = $clog2(BEATS + 1);
   localparam int TERM_W   = 2*DATA_W;
   localparam int RAD_W    = 2*SQRT_W;
   localparam int REM_W    = SQRT_W + 1;
   localparam int SQ_CNT_W = $clog2(SQRT_W + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SQRT, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [RAD_W-1:0]    rad_q, rad_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [SQRT_W-1:0]   root_q, root_d;
   logic [SQ_CNT_W-1:0] sq_cnt_q, sq_cnt_d;
   logic [ACC_W-1:0]    result_q, result_d;

   logic                squared_mode;
   logic                root_mode;
   logic                beat_fire;
   logic                last_beat;
   logic                sqrt_last;
   logic [ACC_W-1:0]    lane_sum;
   logic [REM_W+1:0]    rem_shift;
   logic [REM_W+1:0]    trial;

   // Mode 11 is reserved and behaves like squared Euclidean.
   assign squared_mode = (mode_q != 2'b10);
   assign root_mode    = (mode_q == 2'b01);
   assign beat_fire    = (state_q == ST_ACCUM) && in_valid;
   assign last_beat    = (beat_q == CNT_W'(BEATS - 1));
   assign sqrt_last    = (sq_cnt_q == SQ_CNT_W'(SQRT_W - 1));

   // Restoring root step: bring down the next two radicand bits and try subtracting 4*root+1.
   assign rem_shift = {rem_q, rad_q[RAD_W-1 -: 2]};
   assign trial     = (REM_W+2)'({root_q, 2'b01});

   // Sum of per-lane terms; absolute difference is taken without wrap.
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         logic [DATA_W-1:0] a_el;
         logic [DATA_W-1:0] b_el;
         logic [DATA_W-1:0] diff;
         logic [TERM_W-1:0] term;
         a_el = data_a[i*DATA_W +: DATA_W];
         b_el = data_b[i*DATA_W +: DATA_W];
         diff = (a_el >= b_el) ? (a_el - b_el) : (b_el - a_el);
         if (squared_mode) begin
            term = TERM_W'(diff) * TERM_W'(diff);
         end else begin
            term = TERM_W'(diff);
         end
         lane_sum = lane_sum + ACC_W'(term);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ACCUM;
         ST_ACCUM: if (beat_fire && last_beat) state_d = root_mode ? ST_SQRT : ST_DONE;
         ST_SQRT:  if (sqrt_last) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the state.
   always_comb begin
      in_ready  = (state_q == ST_ACCUM);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
   end

   assign result = result_q;

   // Datapath updates: mode latch, accumulation, square-root iterations, result capture.
   always_comb begin
      mode_d   = mode_q;
      acc_d    = acc_q;
      beat_d   = beat_q;
      rad_d    = rad_q;
      rem_d    = rem_q;
      root_d   = root_q;
      sq_cnt_d = sq_cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d = mode;
               acc_d  = '0;
               beat_d = '0;
            end
         end
         ST_ACCUM: begin
            if (beat_fire) begin
               acc_d  = acc_q + lane_sum;
               beat_d = beat_q + CNT_W'(1);
               if (last_beat) begin
                  // The radicand is loaded here so the root starts on the very next cycle.
                  rad_d    = RAD_W'(acc_d);
                  rem_d    = '0;
                  root_d   = '0;
                  sq_cnt_d = '0;
                  if (!root_mode) result_d = acc_d;
               end
            end
         end
         ST_SQRT: begin
            rad_d    = {rad_q[RAD_W-3:0], 2'b00};
            sq_cnt_d = sq_cnt_q + SQ_CNT_W'(1);
            if (rem_shift >= trial) begin
               rem_d  = REM_W'(rem_shift - trial);
               root_d = SQRT_W'({root_q, 1'b1});
            end else begin
               rem_d  = REM_W'(rem_shift);
               root_d = SQRT_W'({root_q, 1'b0});
            end
            if (sqrt_last) result_d = ACC_W'(root_d);
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q   <= '0;
         acc_q    <= '0;
         beat_q   <= '0;
         rad_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         sq_cnt_q <= '0;
         result_q <= '0;
      end else begin
         mode_q   <= mode_d;
         acc_q    <= acc_d;
         beat_q   <= beat_d;
         rad_q    <= rad_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         sq_cnt_q <= sq_cnt_d;
         result_q <= result_d;
      end
   end

endmodule
